// File: rtl/ingress_pkt_buffer.sv
// Store-and-forward ingress packet buffer feeding one switch input port.
// Buffers whole sop/eop framed packets and releases only committed packets.
// Oversize packets and packets that arrive while the buffer is full are
// discarded and counted in dropCnt. Framing errors (orphan words, missing eop)
// are counted in errCnt.
// Ports:
//   clk, resetN                     clock, async active-low reset
//   inData/inValid/inSop/inEop      MAC-side ingress words
//   outData/outValid/outSop/outEop  registered word to the switch
//   stall                           switch back-pressure, holds the output word
//   dropCnt, errCnt                 saturating event counters
module ingress_pkt_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    input  logic              inSop,
    input  logic              inEop,
    output logic [DATA_W-1:0] outData,
    output logic              outSop,
    output logic              outEop,
    output logic              outValid,
    input  logic              stall,
    output logic [CNT_W-1:0]  dropCnt,
    output logic [CNT_W-1:0]  errCnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] commit_ptr, commit_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] base;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             drop_inc;
    logic             err_inc;
    logic             new_pkt;
    logic             base_full;
    logic             full;
    logic             rewound_full;
    logic             load;

    entry_t mem [DEPTH];

    // Full checks use pre-edge pointers; a same-edge read never makes room.
    assign full         = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
    assign rewound_full = (commit_ptr - rd_ptr) == PTR_W'(DEPTH);
    assign load         = (!outValid || !stall) && (rd_ptr != commit_ptr);

    // Write FSM state and pointer registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
        end
    end

    // Write FSM next state, pointer updates and counter events.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        wr_en          = 1'b0;
        wr_addr        = wr_ptr[AW-1:0];
        drop_inc       = 1'b0;
        err_inc        = 1'b0;
        new_pkt        = 1'b0;
        base           = wr_ptr;
        base_full      = full;

        if (inValid) begin
            unique case (state)
                IDLE: begin
                    if (inSop) new_pkt = 1'b1;
                    else       err_inc = 1'b1;
                end
                RECV: begin
                    if (inSop) begin
                        // Missing eop: discard the open packet, then restart.
                        err_inc    = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        base       = commit_ptr;
                        base_full  = rewound_full;
                        new_pkt    = 1'b1;
                    end else if (!full) begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        if (inEop) begin
                            commit_ptr_nxt = wr_ptr + PTR_W'(1);
                            state_nxt      = IDLE;
                        end
                    end else begin
                        wr_ptr_nxt = commit_ptr;
                        drop_inc   = 1'b1;
                        state_nxt  = inEop ? IDLE : DROP;
                    end
                end
                DROP: begin
                    if (inSop)      new_pkt   = 1'b1;
                    else if (inEop) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase

            if (new_pkt) begin
                if (!base_full) begin
                    wr_en      = 1'b1;
                    wr_addr    = base[AW-1:0];
                    wr_ptr_nxt = base + PTR_W'(1);
                    if (inEop) begin
                        commit_ptr_nxt = base + PTR_W'(1);
                        state_nxt      = IDLE;
                    end else begin
                        state_nxt      = RECV;
                    end
                end else begin
                    drop_inc  = 1'b1;
                    state_nxt = inEop ? IDLE : DROP;
                end
            end
        end
    end

    // Packet storage; contents are don't-care until committed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= '{sop: inSop, eop: inEop, data: inData};
    end

    // Output register: loads committed words, holds everything under stall.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr   <= '0;
            outValid <= 1'b0;
            outSop   <= 1'b0;
            outEop   <= 1'b0;
            outData  <= '0;
        end else if (load) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            outValid <= 1'b1;
            outSop   <= mem[rd_ptr[AW-1:0]].sop;
            outEop   <= mem[rd_ptr[AW-1:0]].eop;
            outData  <= mem[rd_ptr[AW-1:0]].data;
        end else if (!stall) begin
            outValid <= 1'b0;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dropCnt <= '0;
            errCnt  <= '0;
        end else begin
            if (drop_inc && (dropCnt != '1)) dropCnt <= dropCnt + CNT_W'(1);
            if (err_inc && (errCnt != '1))   errCnt  <= errCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ingress_pkt_buffer.sv
// Randomized self-checking bench for ingress_pkt_buffer with a queue-based
// packet-level reference model, plus the directed scenarios.
module tb_ingress_pkt_buffer;

    localparam int DEPTH = 16;

    typedef logic [33:0] w_t;   // {sop, eop, data}

    logic        clk;
    logic        resetN;
    logic [31:0] inData;
    logic        inValid;
    logic        inSop;
    logic        inEop;
    logic [31:0] outData;
    logic        outSop;
    logic        outEop;
    logic        outValid;
    logic        stall;
    logic [7:0]  dropCnt;
    logic [7:0]  errCnt;

    ingress_pkt_buffer #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .resetN(resetN),
        .inData(inData), .inValid(inValid), .inSop(inSop), .inEop(inEop),
        .outData(outData), .outSop(outSop), .outEop(outEop), .outValid(outValid),
        .stall(stall), .dropCnt(dropCnt), .errCnt(errCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: committed-but-unread words, the open packet, the output word.
    w_t cq[$];
    w_t cur[$];
    int mstate;          // 0 idle, 1 receiving, 2 discarding
    bit m_valid;
    w_t m_word;
    int m_drop;
    int m_err;

    function automatic int sat(input int x);
        return (x == 255) ? 255 : x + 1;
    endfunction

    function automatic void model_reset();
        cq.delete();
        cur.delete();
        mstate  = 0;
        m_valid = 1'b0;
        m_word  = '0;
        m_drop  = 0;
        m_err   = 0;
    endfunction

    function automatic void commit_cur();
        foreach (cur[i]) cq.push_back(cur[i]);
        cur.delete();
    endfunction

    function automatic void model_step();
        int occ;
        bit start;
        w_t w;
        occ   = cq.size() + cur.size();
        start = 1'b0;
        w     = {inSop, inEop, inData};
        // Read uses only packets committed before this edge.
        if ((!m_valid || !stall) && cq.size() > 0) begin
            m_word  = cq.pop_front();
            m_valid = 1'b1;
        end else if (!stall) begin
            m_valid = 1'b0;
        end
        if (inValid) begin
            case (mstate)
                0: if (inSop) start = 1'b1; else m_err = sat(m_err);
                1: begin
                    if (inSop) begin
                        m_err = sat(m_err);
                        occ   = occ - cur.size();
                        cur.delete();
                        start = 1'b1;
                    end else if (occ < DEPTH) begin
                        cur.push_back(w);
                        if (inEop) begin commit_cur(); mstate = 0; end
                    end else begin
                        cur.delete();
                        m_drop = sat(m_drop);
                        mstate = inEop ? 0 : 2;
                    end
                end
                default: if (inSop) start = 1'b1; else if (inEop) mstate = 0;
            endcase
            if (start) begin
                if (occ < DEPTH) begin
                    cur.push_back(w);
                    if (inEop) begin commit_cur(); mstate = 0; end
                    else mstate = 1;
                end else begin
                    m_drop = sat(m_drop);
                    mstate = inEop ? 0 : 2;
                end
            end
        end
    endfunction

    task automatic compare_all();
        chk("outValid", 64'(outValid), 64'(m_valid));
        chk("outData",  64'(outData),  64'(m_word[31:0]));
        chk("outSop",   64'(outSop),   64'(m_word[33]));
        chk("outEop",   64'(outEop),   64'(m_word[32]));
        chk("dropCnt",  64'(dropCnt),  64'(m_drop));
        chk("errCnt",   64'(errCnt),   64'(m_err));
    endtask

    // One clock: model sees the same pre-edge inputs as the DUT.
    task automatic tick();
        @(posedge clk);
        if (resetN) model_step();
        else        model_reset();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input logic [31:0] d);
        inValid = v;
        inSop   = s;
        inEop   = e;
        inData  = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input int stall_pct);
        for (int i = 0; i < len; i++) begin
            if (stall_pct >= 0) stall = ($urandom_range(0, 99) < stall_pct);
            drive(1'b1, i == 0, i == len - 1, base + 32'(i));
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2 resetN = 1'b0;
        #1;
        model_reset();
        chk("rst_outValid", 64'(outValid), 64'h0);
        chk("rst_outData",  64'(outData),  64'h0);
        chk("rst_outSop",   64'(outSop),   64'h0);
        chk("rst_outEop",   64'(outEop),   64'h0);
        chk("rst_dropCnt",  64'(dropCnt),  64'h0);
        chk("rst_errCnt",   64'(errCnt),   64'h0);
        inValid = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        resetN  = 1'b1;
        inValid = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0;
        stall   = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Basic transfer.
        send_pkt(2, 32'h45268871, 0);
        chk("basic_wait", 64'(outValid), 64'h0);
        idle(1);
        chk("basic_w0", 64'({outValid, outSop, outData}), 64'({1'b1, 1'b1, 32'h45268871}));
        idle(1);
        chk("basic_w1", 64'({outValid, outEop, outData}), 64'({1'b1, 1'b1, 32'h45268872}));
        idle(1);
        chk("basic_end", 64'(outValid), 64'h0);

        // Stall hold.
        do_reset();
        send_pkt(2, 32'h45268871, 0);
        stall = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("stall_hold", 64'({outSop, outData}), 64'({1'b1, 32'h45268871}));
        end
        stall = 1'b0;
        idle(4);

        // Overflow: 20-word packet dropped, following 2-word packet kept.
        do_reset();
        stall = 1'b1;
        send_pkt(20, 32'h1000, -1);
        send_pkt(2, 32'h79944471, -1);
        chk("ovf_drop", 64'(dropCnt), 64'h1);
        idle(3);
        stall = 1'b0;
        idle(4);

        // Framing errors: orphan, then missing eop, then single-word packet.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h5);
        idle(1);
        chk("orphan_err", 64'(errCnt), 64'h1);
        drive(1'b1, 1'b1, 1'b0, 32'h11);
        drive(1'b1, 1'b0, 1'b0, 32'h22);
        drive(1'b1, 1'b1, 1'b1, 32'h33);
        idle(1);
        chk("frame_err", 64'(errCnt), 64'h2);
        chk("frame_out", 64'({outValid, outSop, outEop, outData}), 64'({3'b111, 32'h33}));
        idle(3);

        // Full boundary: exactly DEPTH words commit; next sop sees full.
        do_reset();
        stall = 1'b1;
        send_pkt(DEPTH, 32'h2000, -1);
        chk("full_commit_drop", 64'(dropCnt), 64'h0);
        send_pkt(2, 32'h3000, -1);
        chk("full_next_drop", 64'(dropCnt), 64'h1);
        stall = 1'b0;
        idle(DEPTH + 4);

        // Reset mid-read and mid-write, then a clean packet.
        send_pkt(6, 32'h4000, 0);
        idle(2);
        send_pkt(3, 32'h5000, 0);
        drive(1'b1, 1'b1, 1'b0, 32'h6000);
        do_reset();
        send_pkt(2, 32'h7000, 0);
        idle(4);

        // Randomized traffic.
        do_reset();
        for (int p = 0; p < 300; p++) begin
            int kind;
            int len;
            int spct;
            kind = $urandom_range(0, 19);
            spct = ($urandom_range(0, 3) == 0) ? 90 : $urandom_range(0, 40);
            len  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 20) : $urandom_range(1, 8);
            if (kind == 0) begin
                drive(1'b1, 1'b0, $urandom_range(0, 1) == 1, $urandom());
            end else if (kind == 1) begin
                for (int i = 0; i < len; i++) begin
                    stall = ($urandom_range(0, 99) < spct);
                    drive(1'b1, i == 0, 1'b0, $urandom());
                end
            end else begin
                send_pkt(len, $urandom(), spct);
            end
            if ($urandom_range(0, 2) == 0) begin
                stall = ($urandom_range(0, 99) < spct);
                idle($urandom_range(1, 3));
            end
        end
        stall = 1'b0;
        idle(DEPTH + 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ingress_pkt_buffer.md
# ingress_pkt_buffer

Per-port store-and-forward packet buffer placed directly upstream of the 2x2 switch; one instance feeds each switch input port (A and B). It accepts 32-bit words framed by sop/eop from the MAC side and buffers whole packets. It releases only complete packets to the switch, honouring the switch's per-port stall. Malformed or oversize packets are discarded and counted, so the switch only ever sees well-framed packets.

## Interface
- DATA_W, 32, data word width
- DEPTH, 16, buffer depth in words; power of two, >= 4
- CNT_W, 8, width of the saturating drop and error counters
- clk  input  1  single clock; all state updates on the rising edge
- resetN  input  1  asynchronous, active-low reset
- inData  input  DATA_W  ingress word
- inValid  input  1  inData/inSop/inEop are valid this cycle
- inSop  input  1  first word of a packet (qualified by inValid)
- inEop  input  1  last word of a packet (qualified by inValid); inSop&inEop together means a single-word packet
- outData  output  DATA_W  word to the switch input (inA/inB)
- outSop  output  1  to the switch sopA/sopB
- outEop  output  1  to the switch eopA/eopB
- outValid  output  1  outData/outSop/outEop are valid
- stall  input  1  from the switch portAStall/portBStall; holds the output word
- dropCnt  output  CNT_W  packets dropped for lack of space; saturates at all-ones
- errCnt  output  CNT_W  framing errors (orphan word, missing eop); saturates at all-ones

## Operation
- Storage is DEPTH entries of {sop, eop, data}. Pointers have log2(DEPTH)+1 bits: wrPtr (speculative), commitPtr, rdPtr.
- Occupancy is wrPtr - rdPtr. The buffer is full when occupancy == DEPTH.
- Write FSM states: IDLE, RECV, DROP. Every input word is one with inValid=1.
  - IDLE, inSop=1, not full: write the word and wrPtr++. If inEop=1, commit (commitPtr <= wrPtr+1) and stay in IDLE; otherwise go to RECV.
  - IDLE, inSop=1, full: dropCnt++. Go to DROP, or stay in IDLE if inEop=1.
  - IDLE, inSop=0: orphan word. Discard it, errCnt++.
  - RECV, inSop=0, not full: write the word and wrPtr++. If inEop=1, commit and go to IDLE.
  - RECV, inSop=0, full: set wrPtr <= commitPtr (rewind), dropCnt++. Go to DROP, or to IDLE if inEop=1.
  - RECV, inSop=1: missing eop. Rewind, errCnt++, then process the word as a new start exactly as in IDLE, against the rewound occupancy.
  - DROP: discard every word. On inEop=1 go to IDLE. If inSop=1 arrives, treat it as a new start as in IDLE (no errCnt).
- The full check uses the pre-edge occupancy. A read on the same edge does not make room.
- Packets longer than DEPTH words are always dropped.
- Read side: one output register {outValid, outSop, outEop, outData}.
  - Load condition: (outValid==0 || stall==0) and rdPtr != commitPtr. Then load mem[rdPtr] and rdPtr++.
  - If the load condition is false and stall==0, clear outValid.
- Uncommitted words are never read. A committed packet streams out while the next packet is still being written.
- Transfer handshake: a word transfers on an edge where outValid=1 and stall=0.
- While stall=1, all out* signals hold their values.

## Timing
- Reset (resetN=0, asynchronous): FSM=IDLE; all pointers 0; outValid=0, outSop=0, outEop=0, outData=0; dropCnt=0, errCnt=0.
  - A packet that was partially written is lost and not counted.
  - A word that was partially read out is lost.
- Latency: eop word sampled at edge E → commit at E. First word of the packet is loaded at E+1, so outValid=1 during the cycle after E+1 when the buffer was empty and stall=0.
- Throughput: one word per cycle in and one out, sustained.
- Output is gap-free within a packet once committed, except while stall=1.
- Counter increments are visible the cycle after the triggering edge.

## Test plan
- Basic transfer: stall=0, send sop 32'h45268871 then eop 32'h45268872 on consecutive cycles.
  - Required: starting one cycle after the eop edge, outData=45268871 with outSop=1, then 45268872 with outEop=1, then outValid=0. dropCnt=0, errCnt=0.
- Stall hold: same packet with stall=1 held for 5 cycles after outValid rises.
  - Required: outData stays 45268871 and outSop stays 1 throughout.
  - After stall falls, both words appear in order, one per cycle.
- Overflow: DEPTH=16, stall=1, send a 20-word packet, then a 2-word packet 32'h79944471/32'h79944472.
  - Required: dropCnt=1 and occupancy returns to 0.
  - After stall falls, only 79944471/79944472 are output.
- Framing errors: send an orphan word (inSop=0) in IDLE → errCnt=1. Then send sop 0x11, data 0x22, sop 0x33 (with eop).
  - Required: errCnt=2, and only the single-word packet 0x33 is output, with outSop=outEop=1.
- Full boundary: fill the buffer with exactly 16 words (sop…eop) while stall=1.
  - Required: the packet commits and dropCnt=0.
  - A following sop word arriving in the same cycle as the first read increments dropCnt to 1.
- Reset mid-operation: assert resetN=0 mid-packet on the write side and mid-packet on the read side.
  - Required: all outputs go to 0 immediately.
  - After release, a new 2-word packet passes intact.
